// File: rtl/ctrl_pipeline.sv
// Control-bit pipeline for the 5-stage core: carries decoder outputs through
// ID/EX, EX/MEM and MEM/WB, derives the EX-stage PC select and counts retires.
module ctrl_pipeline #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_d,
  input  logic             reg_write_d,
  input  logic [1:0]       result_src_d,
  input  logic             mem_write_d,
  input  logic             jump_d,
  input  logic             branch_d,
  input  logic             alu_src_d,
  input  logic [2:0]       alu_control_d,
  input  logic             zero_e,
  input  logic             flush_e,
  input  logic             stall_all,
  output logic             reg_write_e,
  output logic [1:0]       result_src_e,
  output logic             mem_write_e,
  output logic             jump_e,
  output logic             branch_e,
  output logic             alu_src_e,
  output logic [2:0]       alu_control_e,
  output logic             valid_e,
  output logic             pc_src_e,
  output logic             reg_write_m,
  output logic [1:0]       result_src_m,
  output logic             mem_write_m,
  output logic             valid_m,
  output logic             reg_write_w,
  output logic [1:0]       result_src_w,
  output logic             valid_w,
  output logic [CNT_W-1:0] instret
);

  localparam int STAGES = 3;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_control;
  } ex_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } wb_ctrl_t;

  ex_ctrl_t            ctrl_d, ctrl_e;
  mem_ctrl_t           ctrl_m;
  wb_ctrl_t            ctrl_w;
  logic [STAGES:1]     vld_pipe;
  logic [CNT_W-1:0]    instret_q;

  // A mux (not an AND) so X on the control inputs cannot leak into a bubble.
  always_comb begin
    ctrl_d = '0;
    if (valid_d) begin
      ctrl_d.reg_write   = reg_write_d;
      ctrl_d.result_src  = result_src_d;
      ctrl_d.mem_write   = mem_write_d;
      ctrl_d.jump        = jump_d;
      ctrl_d.branch      = branch_d;
      ctrl_d.alu_src     = alu_src_d;
      ctrl_d.alu_control = alu_control_d;
    end
  end

  // Stall freezes everything, flush included; the hazard unit repeats flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_e    <= '0;
      ctrl_m    <= '0;
      ctrl_w    <= '0;
      vld_pipe  <= '0;
      instret_q <= '0;
    end else if (!stall_all) begin
      ctrl_e      <= flush_e ? ex_ctrl_t'('0) : ctrl_d;
      vld_pipe[1] <= valid_d & ~flush_e;
      ctrl_m      <= '{reg_write:  ctrl_e.reg_write,
                       result_src: ctrl_e.result_src,
                       mem_write:  ctrl_e.mem_write};
      ctrl_w      <= '{reg_write:  ctrl_m.reg_write,
                       result_src: ctrl_m.result_src};
      vld_pipe[STAGES:2] <= vld_pipe[STAGES-1:1];
      if (vld_pipe[STAGES])
        instret_q <= instret_q + 1'b1;
    end
  end

  // Side-effect bits are re-gated with their stage valid so a bubble is inert
  // even if a stage register ever held stale control.
  assign reg_write_e   = ctrl_e.reg_write & vld_pipe[1];
  assign result_src_e  = ctrl_e.result_src;
  assign mem_write_e   = ctrl_e.mem_write & vld_pipe[1];
  assign jump_e        = ctrl_e.jump      & vld_pipe[1];
  assign branch_e      = ctrl_e.branch    & vld_pipe[1];
  assign alu_src_e     = ctrl_e.alu_src;
  assign alu_control_e = ctrl_e.alu_control;
  assign valid_e       = vld_pipe[1];
  assign pc_src_e      = vld_pipe[1] & (ctrl_e.jump | (ctrl_e.branch & zero_e));

  assign reg_write_m   = ctrl_m.reg_write & vld_pipe[2];
  assign result_src_m  = ctrl_m.result_src;
  assign mem_write_m   = ctrl_m.mem_write & vld_pipe[2];
  assign valid_m       = vld_pipe[2];

  assign reg_write_w   = ctrl_w.reg_write & vld_pipe[3];
  assign result_src_w  = ctrl_w.result_src;
  assign valid_w       = vld_pipe[3];

  assign instret       = instret_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed + random bench for ctrl_pipeline against an instruction-level
// pipeline model (three slots that shift, retiring whatever leaves WB).
module tb_ctrl_pipeline;
  localparam int CNT_W = 4;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             valid_d, reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]       result_src_d;
  logic [2:0]       alu_control_d;
  logic             zero_e, flush_e, stall_all;
  logic             reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, valid_e, pc_src_e;
  logic [1:0]       result_src_e, result_src_m, result_src_w;
  logic [2:0]       alu_control_e;
  logic             reg_write_m, mem_write_m, valid_m, reg_write_w, valid_w;
  logic [CNT_W-1:0] instret;

  ctrl_pipeline #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .reg_write_d(reg_write_d),
    .result_src_d(result_src_d), .mem_write_d(mem_write_d), .jump_d(jump_d),
    .branch_d(branch_d), .alu_src_d(alu_src_d), .alu_control_d(alu_control_d),
    .zero_e(zero_e), .flush_e(flush_e), .stall_all(stall_all),
    .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
    .jump_e(jump_e), .branch_e(branch_e), .alu_src_e(alu_src_e),
    .alu_control_e(alu_control_e), .valid_e(valid_e), .pc_src_e(pc_src_e),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m), .mem_write_m(mem_write_m),
    .valid_m(valid_m), .reg_write_w(reg_write_w), .result_src_w(result_src_w),
    .valid_w(valid_w), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v, rw, mw, j, b, as;
    bit [1:0] rs;
    bit [2:0] ac;
  } ins_t;

  ins_t        slot[3];   // 0 = EX, 1 = MEM, 2 = WB
  int unsigned retired;
  int          n_assert = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) slot[i] = '{default: 0};
    retired = 0;
  endfunction

  function automatic void model_edge();
    ins_t nx;
    if (stall_all) return;
    if (slot[2].v) retired++;
    slot[2] = slot[1];
    slot[1] = slot[0];
    nx = '{default: 0};
    if (valid_d && !flush_e)
      nx = '{v: 1'b1, rw: reg_write_d, mw: mem_write_d, j: jump_d, b: branch_d,
             as: alu_src_d, rs: result_src_d, ac: alu_control_d};
    slot[0] = nx;
  endfunction

  task automatic check_all();
    chk("valid_e",       valid_e,       slot[0].v);
    chk("reg_write_e",   reg_write_e,   slot[0].rw);
    chk("result_src_e",  result_src_e,  slot[0].rs);
    chk("mem_write_e",   mem_write_e,   slot[0].mw);
    chk("jump_e",        jump_e,        slot[0].j);
    chk("branch_e",      branch_e,      slot[0].b);
    chk("alu_src_e",     alu_src_e,     slot[0].as);
    chk("alu_control_e", alu_control_e, slot[0].ac);
    chk("pc_src_e",      pc_src_e,      slot[0].v & (slot[0].j | (slot[0].b & zero_e)));
    chk("valid_m",       valid_m,       slot[1].v);
    chk("reg_write_m",   reg_write_m,   slot[1].rw);
    chk("result_src_m",  result_src_m,  slot[1].rs);
    chk("mem_write_m",   mem_write_m,   slot[1].mw);
    chk("valid_w",       valid_w,       slot[2].v);
    chk("reg_write_w",   reg_write_w,   slot[2].rw);
    chk("result_src_w",  result_src_w,  slot[2].rs);
    chk("instret",       instret,       retired % (1 << CNT_W));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input bit rw, input bit [1:0] rs, input bit mw,
                       input bit j, input bit b, input bit as, input bit [2:0] ac);
    valid_d = v; reg_write_d = rw; result_src_d = rs; mem_write_d = mw;
    jump_d = j; branch_d = b; alu_src_d = as; alu_control_d = ac;
  endtask

  task automatic idle(); drive(0, 0, 2'b00, 0, 0, 0, 0, 3'b000); endtask
  task automatic drain(); idle(); repeat (4) step(); endtask

  initial begin
    int unsigned r0;
    logic [CNT_W-1:0] held_cnt;
    int k;
    idle(); zero_e = 0; flush_e = 0; stall_all = 0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1; check_all();
    chk("reset_valid_w", valid_w, 0);
    @(negedge clk); rst_n = 1;

    // add-type: E at 1, M at 2, W at 3, counted after 4
    drive(1, 1, 2'b00, 0, 0, 0, 0, 3'b000);
    step(); chk("add_rw_e", reg_write_e, 1);
    idle();
    step(); chk("add_rw_m", reg_write_m, 1);
    step(); chk("add_rw_w", reg_write_w, 1);
    step(); chk("add_instret", instret, 1);

    // beq taken / not taken, then flushed
    drive(1, 0, 2'b00, 0, 0, 1, 0, 3'b001);
    zero_e = 1; step(); chk("beq_taken", pc_src_e, 1);
    idle(); zero_e = 0; #1; chk("beq_not_taken", pc_src_e, 0);
    drive(1, 0, 2'b00, 0, 0, 1, 0, 3'b001);
    flush_e = 1; step(); flush_e = 0; idle();
    zero_e = 1; #1; chk("beq_flushed_z1", pc_src_e, 0);
    zero_e = 0; #1; chk("beq_flushed_z0", pc_src_e, 0);
    // jal: asserts regardless of zero_e
    drive(1, 1, 2'b10, 0, 1, 0, 0, 3'b000);
    step(); chk("jal_pc_src", pc_src_e, 1);
    drain();

    // lw then flush on the next edge
    r0 = retired;
    drive(1, 1, 2'b01, 0, 0, 0, 1, 3'b000);
    step();
    drive(1, 1, 2'b00, 0, 0, 0, 0, 3'b000); flush_e = 1;
    step(); flush_e = 0;
    chk("lw_rs_m", result_src_m, 2'b01);
    chk("lw_bubble_v", valid_e, 0);
    chk("lw_bubble_rw", reg_write_e, 0);
    drain();
    chk("lw_instret", instret, (r0 + 1) % (1 << CNT_W));

    // sw in EX, stall 3 cycles with flush asserted throughout
    drive(1, 0, 2'b00, 1, 0, 0, 1, 3'b000);
    step();
    held_cnt = instret;
    drive(1, 1, 2'b01, 0, 1, 0, 0, 3'b111);
    stall_all = 1; flush_e = 1;
    repeat (3) begin
      step();
      chk("stall_sw_e", mem_write_e, 1);
      chk("stall_valid_e", valid_e, 1);
      chk("stall_instret", instret, held_cnt);
    end
    stall_all = 0; flush_e = 0; idle();
    step(); chk("sw_mem_write_m", mem_write_m, 1);
    drain();

    // counter wrap: 17 back-to-back retires from zero
    @(negedge clk); rst_n = 0; model_reset(); #1; check_all();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 2'b00, 0, 0, 0, 0, 3'(i));
      step();
    end
    idle();
    k = 0;
    while (retired != 15 && k < 10) begin step(); k++; end
    chk("wrap_reach15", retired, 15);
    chk("wrap_15", instret, 15);
    step(); chk("wrap_0", instret, 0);
    step(); chk("wrap_1", instret, 1);
    drain();

    // async reset mid-cycle with three in flight
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b00, (i == 1), 0, 0, 0, 3'b010);
      step();
    end
    idle();
    #2 rst_n = 0; model_reset();
    #1;
    check_all();
    chk("rst_valid_e", valid_e, 0);
    chk("rst_mem_write_m", mem_write_m, 0);
    chk("rst_instret", instret, 0);
    #1 rst_n = 1;
    repeat (4) step();
    chk("rst_no_retire", instret, 0);

    // X on control inputs while invalid
    valid_d = 0; reg_write_d = 'x; result_src_d = 'x; mem_write_d = 'x;
    jump_d = 'x; branch_d = 'x; alu_src_d = 'x; alu_control_d = 'x;
    step();
    chk("x_rw_e", reg_write_e, 0);
    chk("x_ac_e", alu_control_e, 0);
    idle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), bit'($urandom), 2'($urandom_range(0, 2)),
            bit'($urandom), bit'($urandom_range(0, 4) == 0), bit'($urandom_range(0, 3) == 0),
            bit'($urandom), 3'($urandom));
      zero_e    = bit'($urandom);
      flush_e   = ($urandom_range(0, 5) == 0);
      stall_all = ($urandom_range(0, 7) == 0);
      step();
    end
    stall_all = 0; flush_e = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
